fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the pipelined MIPS core.
- Owns the program counter and drives the byte address into instr_memory.
- Captures the returned instruction word and PC+4 into the IF/ID pipeline register consumed by decode.
- Applies stall, branch/jump redirect, flush and halt requests coming back from ID/hazard logic.

Parameters:
- PROGRAM_START, 32'h00400020, PC value loaded on reset (first instruction byte address).
- NOP_INSTR, 32'h00000000, bubble instruction written into IF/ID on flush/halt.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  squash the instruction being fetched this cycle (load bubble).
- branch_taken  input  1  ID resolved a taken branch.
- branch_target  input  32  branch byte address.
- jump  input  1  ID decoded j/jal/jr.
- jump_target  input  32  jump byte address.
- halt  input  1  ID decoded exit syscall; stop fetching.
- instr_in  input  32  instruction word from instr_memory for pc_out.
- pc_out  output  32  byte address to instr_memory.
- if_id_instr  output  32  IF/ID instruction register.
- if_id_pc_plus4  output  32  IF/ID PC+4 register.
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  stage is in HALTED state.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - pc_out = PROGRAM_START.
  - if_id_instr = NOP_INSTR, if_id_pc_plus4 = 0, if_id_valid = 0.
  - halted = 0; state = RUN.
- Latency: instr_memory is combinational; the instruction at pc_out appears in IF/ID one clock edge later.
- State machine, two states:
  - RUN: normal fetch.
  - HALTED: entered on the edge where halt=1 in RUN; left only by rst.
- Per-edge priority in RUN, highest first:
  1. rst.
  2. halt:
     - PC holds.
     - IF/ID loads bubble (NOP_INSTR, valid=0, pc_plus4 unchanged).
     - state goes to HALTED.
  3. Redirect (jump or branch_taken):
     - PC <= jump_target if jump, else branch_target. Jump wins if both are asserted.
     - IF/ID loads bubble, because the sequentially fetched instruction is wrong-path.
     - Redirect overrides stall.
  4. stall: PC and all IF/ID registers hold their values.
  5. flush (no stall): PC <= PC+4; IF/ID loads bubble.
  6. Normal: PC <= PC+4; if_id_instr <= instr_in; if_id_pc_plus4 <= PC+4; if_id_valid <= 1.
- HALTED:
  - PC frozen; IF/ID stays bubble; halted = 1.
  - All other inputs ignored.
- Arithmetic and width rules:
  - PC+4 is 32-bit modulo; 0xFFFFFFFC wraps to 0x00000000 with no error flag.
  - Bits [1:0] of the targets are forced to 0 when loaded.
  - PC[1:0] is always 0.
- Reset mid-operation (including while HALTED or stalled) returns every output to its reset values on that edge.

Decomposition:
- Shared package/header (mips_defs):
  - PROGRAM_START and NOP_INSTR constants.
  - Fetch state encoding (RUN=1'b0, HALTED=1'b1).
  - Word-size constant 4.
- One sub-module is natural: if_id_reg, the IF/ID pipeline register.
  - Inputs: clk, rst, enable (= !stall), bubble, instr, pc_plus4.
  - Outputs: the registered instr, pc_plus4 and valid.
  - Reused later as the template for the ID/EX register.
- PC register, next-PC mux and state machine stay in fetch_stage.

Test Plan:
1. Reset, then normal fetch:
   - Stimulus: rst=1 for one edge, then instr_in tracks memory holding 0x24080001, 0x24090002 at 0x00400020 and 0x00400024.
   - Required: after reset, pc_out=0x00400020 and if_id_valid=0.
   - Edge 1: if_id_instr=0x24080001, if_id_pc_plus4=0x00400024, pc_out=0x00400024.
   - Edge 2: if_id_instr=0x24090002, pc_out=0x00400028.
2. Stall:
   - Stimulus: stall=1 for 2 edges at pc_out=0x00400024.
   - Required: pc_out stays 0x00400024; if_id_instr stays 0x24080001; valid stays 1; normal sequence resumes after stall drops.
3. Branch redirect with simultaneous stall:
   - Stimulus: branch_taken=1, branch_target=0x00400040, stall=1.
   - Required: next pc_out=0x00400040; if_id_instr=0x00000000; if_id_valid=0.
   - Then jump=1 together with branch_taken=1, jump_target=0x00400100 -> pc_out=0x00400100.
4. Flush:
   - Stimulus: flush=1 at pc_out=0x00400028.
   - Required: pc_out=0x0040002C; if_id_valid=0; if_id_instr=0.
5. Halt and reset out of HALTED:
   - Stimulus: halt=1 at pc_out=0x00400038.
   - Required: pc_out stays 0x00400038 indefinitely; halted=1; IF/ID stays bubble.
   - branch_taken/flush pulses while HALTED are ignored.
   - rst=1 -> pc_out=0x00400020, halted=0.
6. Wrap-around and alignment:
   - Stimulus: jump to 0xFFFFFFFE.
   - Required: pc_out=0xFFFFFFFC; next edge pc_out=0x00000000 and if_id_pc_plus4=0x00000000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encoding and helpers for the MIPS instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_PROGRAM_START = 32'h0040_0020;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR     = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_BYTES        = 32'd4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // Drop the byte offset so every loaded PC is word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control/redirect inputs, instruction-memory port and IF/ID outputs of the fetch stage.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            stall;
    logic            flush;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            halt;
    logic [XLEN-1:0] instr_in;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic            if_id_valid;
    logic            halted;

    // Drives decode/hazard requests and the memory return path.
    modport master (
        output stall, flush, branch_taken, branch_target, jump, jump_target, halt, instr_in,
        input  pc_out, if_id_instr, if_id_pc_plus4, if_id_valid, halted
    );

    // The fetch stage itself.
    modport slave (
        input  stall, flush, branch_taken, branch_target, jump, jump_target, halt, instr_in,
        output pc_out, if_id_instr, if_id_pc_plus4, if_id_valid, halted
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds when disabled, loads a bubble (pc_plus4 kept) or a fetched word.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_enable,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc_plus4,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_enable) begin
            if (i_bubble) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else begin
                r_instr    <= i_instr;
                r_pc_plus4 <= i_pc_plus4;
                r_valid    <= 1'b1;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: program counter, next-PC selection, RUN/HALTED control and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] PROGRAM_START = DEF_PROGRAM_START,
    parameter logic [XLEN-1:0] NOP_INSTR     = DEF_NOP_INSTR
) (
    input  logic           clk,
    input  logic           rst,
    fetch_stage_if.slave   fe
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_target;
    logic            w_redirect;
    logic            w_ifid_enable;
    logic            w_ifid_bubble;

    assign w_pc_plus4        = XLEN'(r_pc + WORD_BYTES);
    assign w_redirect        = fe.jump | fe.branch_taken;
    assign w_redirect_target = align_word(fe.jump ? fe.jump_target : fe.branch_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= PROGRAM_START;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Priority in RUN: halt, redirect (beats stall), stall, flush, sequential fetch.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_ifid_enable = 1'b0;
        w_ifid_bubble = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (fe.halt) begin
                    w_state_next  = ST_HALTED;
                    w_ifid_enable = 1'b1;
                    w_ifid_bubble = 1'b1;
                end else if (w_redirect) begin
                    w_pc_next     = w_redirect_target;
                    w_ifid_enable = 1'b1;
                    w_ifid_bubble = 1'b1;
                end else if (!fe.stall) begin
                    w_pc_next     = w_pc_plus4;
                    w_ifid_enable = 1'b1;
                    w_ifid_bubble = fe.flush;
                end
            end
            ST_HALTED: begin
                w_ifid_enable = 1'b1;
                w_ifid_bubble = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (w_ifid_enable),
        .i_bubble   (w_ifid_bubble),
        .i_instr    (fe.instr_in),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (fe.if_id_instr),
        .o_pc_plus4 (fe.if_id_pc_plus4),
        .o_valid    (fe.if_id_valid)
    );

    assign fe.pc_out = r_pc;
    assign fe.halted = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: what the stage should hold after each edge.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_halted;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .fe  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0040_0020: return 32'h2408_0001;
            32'h0040_0024: return 32'h2409_0002;
            default:       return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign bus.instr_in = mem_word(bus.pc_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, clock the DUT and compare every output.
    task automatic step(input logic r, input logic st, input logic fl, input logic br,
                        input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                        input logic hl);
        logic [31:0] tgt;
        rst               = r;
        bus.stall         = st;
        bus.flush         = fl;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.jump          = jp;
        bus.jump_target   = jt;
        bus.halt          = hl;
        tgt = jp ? jt : bt;
        tgt[1:0] = 2'b00;
        if (r) begin
            m_pc = 32'h0040_0020; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end else if (hl) begin
            m_instr = 32'h0; m_valid = 1'b0; m_halted = 1'b1;
        end else if (jp || br) begin
            m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (fl) begin
            m_pc = m_pc + 32'd4; m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check("pc_out",         bus.pc_out,              m_pc);
        check("if_id_instr",    bus.if_id_instr,         m_instr);
        check("if_id_pc_plus4", bus.if_id_pc_plus4,      m_pc4);
        check("if_id_valid",    32'(bus.if_id_valid),    32'(m_valid));
        check("halted",         32'(bus.halted),         32'(m_halted));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic jump_to(input logic [31:0] t);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, t, 1'b0);
    endtask

    initial begin
        m_pc = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_halted = 1'b0;

        // Reset, then sequential fetch
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst_pc",    bus.pc_out,           32'h0040_0020);
        check("rst_valid", 32'(bus.if_id_valid), 32'd0);
        idle();
        check("e1_instr", bus.if_id_instr,    32'h2408_0001);
        check("e1_pc4",   bus.if_id_pc_plus4, 32'h0040_0024);
        check("e1_pc",    bus.pc_out,         32'h0040_0024);

        // Stall two edges, then resume
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("stall_pc",    bus.pc_out,           32'h0040_0024);
        check("stall_instr", bus.if_id_instr,      32'h2408_0001);
        check("stall_valid", 32'(bus.if_id_valid), 32'd1);
        idle();
        check("e2_instr", bus.if_id_instr, 32'h2409_0002);
        check("e2_pc",    bus.pc_out,      32'h0040_0028);

        // Branch overriding stall, then jump beating branch
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 32'h0, 1'b0);
        check("br_pc",    bus.pc_out,           32'h0040_0040);
        check("br_instr", bus.if_id_instr,      32'h0);
        check("br_valid", 32'(bus.if_id_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0100, 1'b0);
        check("jmp_pc", bus.pc_out, 32'h0040_0100);

        // Flush
        jump_to(32'h0040_0028);
        idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("fl_pc",    bus.pc_out,           32'h0040_0030);
        check("fl_valid", 32'(bus.if_id_valid), 32'd0);
        check("fl_instr", bus.if_id_instr,      32'h0);

        // Halt; ignored inputs while halted; reset out
        jump_to(32'h0040_0038);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0080, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_1000, 1'b0);
        idle();
        check("halt_pc",    bus.pc_out,           32'h0040_0038);
        check("halt_flag",  32'(bus.halted),      32'd1);
        check("halt_valid", 32'(bus.if_id_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("unhalt_pc",   bus.pc_out,      32'h0040_0020);
        check("unhalt_flag", 32'(bus.halted), 32'd0);

        // Unaligned target and 32-bit wrap
        jump_to(32'hFFFF_FFFE);
        check("wrap_align", bus.pc_out, 32'hFFFF_FFFC);
        idle();
        check("wrap_pc",  bus.pc_out,         32'h0000_0000);
        check("wrap_pc4", bus.if_id_pc_plus4, 32'h0000_0000);

        // Randomized control traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt;
            logic [31:0] jt;
            bt = $urandom;
            jt = $urandom;
            step(1'b0 | ($urandom_range(99) < 4),
                 $urandom_range(99) < 25,
                 $urandom_range(99) < 12,
                 $urandom_range(99) < 8, bt,
                 $urandom_range(99) < 8, jt,
                 $urandom_range(99) < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
